// File: rtl/uart_rx_os_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_os_if                                                   |
// | Purpose  : Receive-word stream (valid/ready) from uart_rx_os to consumer.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output m_data, m_parity_err, m_frame_err, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_parity_err, m_frame_err, m_valid,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_os                                                      |
// | Purpose  : Oversampling UART receiver, majority-vote bit decisions, FWFT   |
// |            output FIFO with per-word parity/frame error flags.             |
// | Options  : UART_RX_BREAK_EN adds break detection and the break_det port.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_os #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  uart_rx_os_if.master                  m_if,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_RX_BREAK_EN
  ,
  output logic                          break_det
`endif
);

  localparam int             DIV       = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam logic [15:0]    DIV_LAST  = 16'(DIV - 1);
  localparam int             SC_W      = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_A     = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_B     = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_C     = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam int             BC_W      = 4;
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);
  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam int             CNT_W     = PTR_W + 1;
  localparam int             W         = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_sync_q, rx_sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [15:0]            div_q, div_d;
  logic [SC_W-1:0]        sc_q, sc_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   overrun_q, overrun_d;
  logic [PTR_W-1:0]       wr_q, wr_d;
  logic [PTR_W-1:0]       rd_q, rd_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [W-1:0]           mem_q [FIFO_DEPTH];
  logic [W-1:0]           mem_d [FIFO_DEPTH];

  logic                   tick;
  logic                   fall;
  logic                   decide;
  logic                   vote;
  logic                   parity_exp;
  logic                   push;
  logic [W-1:0]           push_word;
  logic                   full;
  logic                   do_push;
  logic                   do_pop;

`ifdef UART_RX_BREAK_EN
  logic                   zero_q, zero_d;
  logic                   break_q, break_d;
  logic                   brk;
`endif

  assign tick       = (div_q == DIV_LAST);
  assign fall       = rx_prev_q & ~rx_sync_q;
  assign decide     = tick && (sc_q == SC_C);
  assign vote       = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign parity_exp = (PARITY == 1) ? ~(^data_q) : (^data_q);

  // Receive FSM plus bit-timing counters.
  always_comb begin
    state_d   = state_q;
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    div_d     = tick ? 16'd0 : div_q + 16'd1;
    sc_d      = sc_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;
`ifdef UART_RX_BREAK_EN
    brk       = 1'b0;
`endif

    if (tick) begin
      sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
      if (sc_q == SC_A) s0_d = rx_sync_q;
      if (sc_q == SC_B) s1_d = rx_sync_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d   = S_START;
          div_d     = 16'd0;
          sc_d      = '0;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        if (decide) state_d = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          data_d = {vote, data_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_d  = (vote != parity_exp);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          ferr_d = ferr_q | ~vote;
          if (bit_cnt_q == STOP_LAST) begin
            // Leave mid-bit so the next start edge is caught without delay.
            state_d = S_IDLE;
`ifdef UART_RX_BREAK_EN
            if (zero_q & ~vote) begin
              brk     = 1'b1;
              state_d = S_BRK_WAIT;
            end else begin
              push = 1'b1;
            end
`else
            push = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      S_BRK_WAIT: begin
        // Re-arm only after one full bit time of continuous idle-high line.
        if (!rx_sync_q)                   sc_d    = '0;
        else if (tick && sc_q == SC_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push_word = {ferr_d, perr_q, data_q};

`ifdef UART_RX_BREAK_EN
  always_comb begin
    zero_d  = zero_q;
    break_d = brk;
    if (state_q == S_IDLE && fall) zero_d = 1'b1;
    else if (decide && (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP))
      zero_d = zero_q & ~vote;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      break_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      break_q <= break_d;
    end
  end

  assign break_det = break_q;
`endif

  // Output FIFO, first-word fall-through.
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = (count_q != '0) & m_if.m_ready;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    overrun_d = push & full & ~do_pop;
    if (do_push) begin
      mem_d[wr_q] = push_word;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) rd_d = rd_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= 16'd0;
      sc_q      <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      data_q    <= '0;
      bit_cnt_q <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      div_q     <= div_d;
      sc_q      <= sc_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign m_if.m_data       = mem_q[rd_q][DATA_BITS-1:0];
  assign m_if.m_parity_err = mem_q[rd_q][DATA_BITS];
  assign m_if.m_frame_err  = mem_q[rd_q][DATA_BITS+1];
  assign m_if.m_valid      = (count_q != '0);
  assign overrun           = overrun_q;
  assign fifo_count        = count_q;

endmodule
`default_nettype wire
